// File: rtl/fpga_pad_cond_pkg.sv
// ----------------------------------------------------------------------------
// fpga_pad_cond_pkg
// Shared definitions for the board pad conditioner:
//   - rst_seq_state_e : reset sequencer states (HOLD, COUNT, RUN)
//   - *_DEF           : default values for the conditioner parameters
//   - cnt_width()     : width of a counter that must hold values 0..n
// ----------------------------------------------------------------------------
package fpga_pad_cond_pkg;

    localparam int NUM_IN_DEF          = 8;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int RST_HOLD_CYCLES_DEF = 1024;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } rst_seq_state_e;

    // $clog2(n+1), never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pad_debounce.sv
// ----------------------------------------------------------------------------
// pad_debounce
// One board input channel: synchroniser, optional inversion, debounce counter
// and registered rise/fall pulses.
//
// Ports:
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   sync_valid_i : high once the synchroniser chain holds real pad samples
//   pad_i        : raw pad level, asynchronous to clk_i
//   level_o      : debounced, polarity-corrected level
//   rise_o       : one-cycle pulse on the cycle level_o goes 0->1
//   fall_o       : one-cycle pulse on the cycle level_o goes 1->0
// ----------------------------------------------------------------------------
module pad_debounce
    import fpga_pad_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_valid_i,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   s;
    logic                   differ;

    assign s      = sync_reg[SYNC_STAGES-1] ^ INVERT;
    assign differ = (s != level_reg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_i};
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            // Right after reset the chain still holds cleared flops rather
            // than pad samples; counting waits until real samples arrive so
            // the edge-to-output latency is the same as in steady state.
            if (!sync_valid_i || !differ) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= s;
                rise_reg  <= s;
                fall_reg  <= ~s;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign level_o = level_reg;
    assign rise_o  = rise_reg;
    assign fall_o  = fall_reg;

endmodule

// File: rtl/fpga_pad_conditioner.sv
// ----------------------------------------------------------------------------
// fpga_pad_conditioner
// Conditions raw board buttons/switches (synchronise, invert, debounce, edge
// detect) and sequences the SoC reset from the board reset button.
//
// Ports:
//   clk_i       : single clock, all logic in this domain
//   rst_ni      : asynchronous active-low reset
//   pad_reset_i : raw active-high board reset button (asynchronous)
//   in_i        : raw board inputs (asynchronous)
//   in_o        : debounced, polarity-corrected levels
//   rise_o      : one-cycle pulse per channel on 0->1 of in_o
//   fall_o      : one-cycle pulse per channel on 1->0 of in_o
//   soc_rst_no  : registered active-low SoC reset
// ----------------------------------------------------------------------------
module fpga_pad_conditioner
    import fpga_pad_cond_pkg::*;
#(
    parameter int              NUM_IN          = NUM_IN_DEF,
    parameter int              SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int              DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int              RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
    parameter logic [NUM_IN-1:0] INVERT_MASK   = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pad_reset_i,
    input  logic [NUM_IN-1:0] in_i,
    output logic [NUM_IN-1:0] in_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic              soc_rst_no
);

    localparam int            HW        = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

    // Shift register of ones that marks when every synchroniser chain has
    // been refilled with real pad samples after reset. Both the debouncers
    // and the reset sequencer ignore the chains until then.
    logic [SYNC_STAGES-1:0] sync_fill_reg;
    logic                   sync_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_fill_reg <= '0;
        end else begin
            sync_fill_reg <= {sync_fill_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_valid = sync_fill_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Input channels
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            pad_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT_MASK[gi])
            ) u_pad_debounce (
                .clk_i        (clk_i),
                .rst_ni       (rst_ni),
                .sync_valid_i (sync_valid),
                .pad_i        (in_i[gi]),
                .level_o      (in_o[gi]),
                .rise_o       (rise_o[gi]),
                .fall_o       (fall_o[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_reg;
    logic                   r_sync;
    rst_seq_state_e         state_reg;
    rst_seq_state_e         state_next;
    logic [HW-1:0]          hold_cnt_reg;
    logic [HW-1:0]          hold_cnt_next;
    logic                   soc_rst_n_reg;

    assign r_sync = rst_sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            HOLD: begin
                hold_cnt_next = '0;
                if (sync_valid && !r_sync) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                // A press during the count throws away the partial hold, so
                // the next release always waits the full hold time.
                if (r_sync) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = RUN;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
            RUN: begin
                if (r_sync) begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next    = HOLD;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_reg  <= '0;
            state_reg     <= HOLD;
            hold_cnt_reg  <= '0;
            soc_rst_n_reg <= 1'b0;
        end else begin
            rst_sync_reg  <= {rst_sync_reg[SYNC_STAGES-2:0], pad_reset_i};
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            // Decoded from the current state, so the SoC sees release one
            // cycle after RUN is entered and reset one cycle after HOLD.
            soc_rst_n_reg <= (state_reg == RUN);
        end
    end

    assign soc_rst_no = soc_rst_n_reg;

endmodule

// File: tb/tb_fpga_pad_conditioner.sv
// ----------------------------------------------------------------------------
// tb_fpga_pad_conditioner
// Scoreboard bench: stimulus tasks push expected output values tagged with
// the absolute cycle they are due; a monitor on the falling edge pops and
// compares them. Asynchronous-reset behaviour is checked directly.
// Configuration: NUM_IN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// RST_HOLD_CYCLES=8, INVERT_MASK=4'b1000.
// ----------------------------------------------------------------------------
module tb_fpga_pad_conditioner;

    localparam int F_IN   = 0;
    localparam int F_RISE = 1;
    localparam int F_FALL = 2;
    localparam int F_SOC  = 3;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       pad_reset_i;
    logic [3:0] in_i;
    logic [3:0] in_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic       soc_rst_no;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        int         fld;
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fpga_pad_conditioner #(
        .NUM_IN          (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RST_HOLD_CYCLES (8),
        .INVERT_MASK     (4'b1000)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .pad_reset_i (pad_reset_i),
        .in_i        (in_i),
        .in_o        (in_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .soc_rst_no  (soc_rst_no)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end else begin
            $display("ok   %s cyc=%0d val=%0h", tag, cyc, obs);
        end
    endtask

    function automatic logic [3:0] observe(input int fld);
        case (fld)
            F_IN:    return in_o;
            F_RISE:  return rise_o;
            F_FALL:  return fall_o;
            default: return {3'b000, soc_rst_no};
        endcase
    endfunction

    // Insert keeping the queue ordered by due cycle.
    task automatic expect_at(input int at, input int fld, input logic [3:0] val, input string tag);
        exp_t e;
        int   i;
        e.at  = at;
        e.fld = fld;
        e.val = val;
        e.tag = tag;
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at == cyc) check(e.tag, observe(e.fld), e.val);
            else             check({e.tag, "_late"}, cyc, e.at);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t;
        int u;

        rst_ni      = 1'b0;
        pad_reset_i = 1'b0;
        in_i        = 4'b0000;
        tick(3);
        check("rst_in_o", in_o, 4'b0000);
        check("rst_rise", rise_o, 4'b0000);
        check("rst_fall", fall_o, 4'b0000);
        check("rst_soc", soc_rst_no, 1'b0);

        // Release: inverted channel 3 rises after 6, SoC reset lifts at 12.
        c0 = cyc;
        rst_ni = 1'b1;
        expect_at(c0 + 1,  F_SOC,  4'h0,    "rel_soc_c1");
        expect_at(c0 + 5,  F_IN,   4'b0000, "rel_in_c5");
        expect_at(c0 + 5,  F_RISE, 4'b0000, "rel_rise_c5");
        expect_at(c0 + 6,  F_IN,   4'b1000, "rel_in_c6");
        expect_at(c0 + 6,  F_RISE, 4'b1000, "rel_rise_c6");
        expect_at(c0 + 6,  F_FALL, 4'b0000, "rel_fall_c6");
        expect_at(c0 + 7,  F_RISE, 4'b0000, "rel_rise_c7");
        expect_at(c0 + 11, F_SOC,  4'h0,    "rel_soc_c11");
        expect_at(c0 + 12, F_SOC,  4'h1,    "rel_soc_c12");
        tick(20);

        // Clean edge on channel 0.
        t = cyc;
        in_i[0] = 1'b1;
        expect_at(t + 5, F_IN,   4'b1000, "ch0_in_c5");
        expect_at(t + 6, F_IN,   4'b1001, "ch0_in_c6");
        expect_at(t + 6, F_RISE, 4'b0001, "ch0_rise_c6");
        expect_at(t + 6, F_FALL, 4'b0000, "ch0_fall_c6");
        expect_at(t + 7, F_RISE, 4'b0000, "ch0_rise_c7");
        expect_at(t + 7, F_FALL, 4'b0000, "ch0_fall_c7");
        tick(10);

        // Channel 1: 3-cycle glitch rejected.
        t = cyc;
        in_i[1] = 1'b1;
        tick(3);
        in_i[1] = 1'b0;
        expect_at(t + 6, F_IN,   4'b1001, "gl_in_c6");
        expect_at(t + 6, F_RISE, 4'b0000, "gl_rise_c6");
        expect_at(t + 8, F_IN,   4'b1001, "gl_in_c8");
        tick(8);

        // Channel 1: 5-cycle pulse accepted, then released.
        u = cyc;
        in_i[1] = 1'b1;
        tick(5);
        in_i[1] = 1'b0;
        expect_at(u + 6,  F_IN,   4'b1011, "p5_in_c6");
        expect_at(u + 6,  F_RISE, 4'b0010, "p5_rise_c6");
        expect_at(u + 6,  F_FALL, 4'b0000, "p5_fall_c6");
        expect_at(u + 7,  F_RISE, 4'b0000, "p5_rise_c7");
        expect_at(u + 10, F_IN,   4'b1011, "p5_in_c10");
        expect_at(u + 11, F_IN,   4'b1001, "p5_in_c11");
        expect_at(u + 11, F_FALL, 4'b0010, "p5_fall_c11");
        expect_at(u + 11, F_RISE, 4'b0000, "p5_rise_c11");
        expect_at(u + 12, F_FALL, 4'b0000, "p5_fall_c12");
        tick(10);

        // Pad reset in RUN, release, then re-press during COUNT.
        t = cyc;
        pad_reset_i = 1'b1;
        expect_at(t + 3, F_SOC, 4'h1, "pr_soc_c3");
        expect_at(t + 4, F_SOC, 4'h0, "pr_soc_c4");
        tick(6);
        pad_reset_i = 1'b0;
        tick(6);
        pad_reset_i = 1'b1;
        tick(2);
        pad_reset_i = 1'b0;
        expect_at(t + 17, F_SOC, 4'h0, "rp_soc_c17");
        expect_at(t + 18, F_SOC, 4'h0, "rp_soc_c18");
        expect_at(t + 25, F_SOC, 4'h0, "rp_soc_c25");
        expect_at(t + 26, F_SOC, 4'h1, "rp_soc_c26");
        tick(20);

        // Async reset in the middle of a debounce on channel 2.
        t = cyc;
        in_i[2] = 1'b1;
        expect_at(t + 1, F_SOC, 4'h1,    "md_soc_c1");
        expect_at(t + 2, F_IN,  4'b1001, "md_in_c2");
        tick(3);
        rst_ni = 1'b0;
        #1;
        check("arst_in_o", in_o, 4'b0000);
        check("arst_rise", rise_o, 4'b0000);
        check("arst_fall", fall_o, 4'b0000);
        check("arst_soc", soc_rst_no, 1'b0);
        tick(3);

        // Inputs held high through reset rise together after release.
        c0 = cyc;
        rst_ni = 1'b1;
        expect_at(c0 + 5,  F_IN,   4'b0000, "rel2_in_c5");
        expect_at(c0 + 6,  F_IN,   4'b1101, "rel2_in_c6");
        expect_at(c0 + 6,  F_RISE, 4'b1101, "rel2_rise_c6");
        expect_at(c0 + 6,  F_FALL, 4'b0000, "rel2_fall_c6");
        expect_at(c0 + 7,  F_RISE, 4'b0000, "rel2_rise_c7");
        expect_at(c0 + 11, F_SOC,  4'h0,    "rel2_soc_c11");
        expect_at(c0 + 12, F_SOC,  4'h1,    "rel2_soc_c12");
        tick(20);

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga_pad_conditioner.md
FPGA_PAD_CONDITIONER -- requirements
Module: fpga_pad_conditioner

Interface
REQ-001: Parameter NUM_IN, default 8, number of board input channels (buttons/switches), range 1..32.
REQ-002: Parameter SYNC_STAGES, default 2, synchroniser flops per input, range 2..4.
REQ-003: Parameter DEBOUNCE_CYCLES, default 50000, stable cycles required before an input change is accepted, minimum 1.
REQ-004: Parameter RST_HOLD_CYCLES, default 1024, cycles the SoC reset stays asserted after pad reset release, minimum 1.
REQ-005: Parameter INVERT_MASK, default all-zero, NUM_IN bits; a 1 inverts that channel after synchronisation.
REQ-006: clk_i  input  1  single clock; all logic in this domain.
REQ-007: rst_ni  input  1  asynchronous active-low reset.
REQ-008: pad_reset_i  input  1  raw active-high board reset button, asynchronous to clk_i.
REQ-009: in_i  input  NUM_IN  raw board inputs, asynchronous to clk_i.
REQ-010: in_o  output  NUM_IN  debounced, polarity-corrected levels.
REQ-011: rise_o  output  NUM_IN  one-cycle pulse when in_o[i] goes 0->1.
REQ-012: fall_o  output  NUM_IN  one-cycle pulse when in_o[i] goes 1->0.
REQ-013: soc_rst_no  output  1  registered active-low SoC reset, released synchronously to clk_i.

Function
REQ-014: Each channel SHALL pass in_i[i] through SYNC_STAGES flops, then XOR with INVERT_MASK[i], giving s[i].
REQ-015: Counter cnt[i] (width $clog2(DEBOUNCE_CYCLES+1)) SHALL clear whenever s[i] equals in_o[i].
REQ-016: While s[i] differs from in_o[i], cnt[i] SHALL increment each cycle; on the cycle cnt[i]==DEBOUNCE_CYCLES-1, in_o[i] SHALL take s[i] next cycle and cnt[i] SHALL clear.
REQ-017: A glitch shorter than DEBOUNCE_CYCLES cycles at s[i] SHALL NOT change in_o[i]; the count SHALL restart from 0 on the next difference.
REQ-018: Latency from a clean in_i edge to in_o change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles.
REQ-019: rise_o[i]/fall_o[i] SHALL assert in the same cycle in_o[i] changes, for exactly one cycle; never both together.
REQ-020: Counters SHALL never wrap; cnt[i] maximum is DEBOUNCE_CYCLES-1.
REQ-021: pad_reset_i SHALL be synchronised through SYNC_STAGES flops to r_sync.
REQ-022: Reset sequencer FSM states HOLD, COUNT, RUN; HOLD->COUNT when r_sync==0 (hold counter cleared); COUNT->RUN when hold counter==RST_HOLD_CYCLES-1; COUNT->HOLD or RUN->HOLD whenever r_sync==1.
REQ-023: soc_rst_no SHALL be a flop equal to 1 only while state is RUN, so it deasserts one cycle after the COUNT->RUN transition and asserts one cycle after entry to HOLD.
REQ-024: Pad reset re-asserted mid-COUNT SHALL restart the full RST_HOLD_CYCLES hold after next release.

Reset
REQ-025: On rst_ni low, all synchroniser flops, cnt, in_o, rise_o, fall_o and hold counter SHALL clear to 0 and the FSM SHALL enter HOLD, immediately.
REQ-026: soc_rst_no SHALL be 0 asynchronously while rst_ni is low and SHALL stay 0 at least SYNC_STAGES+RST_HOLD_CYCLES+1 cycles after rst_ni release.
REQ-027: An input held at 1 (after inversion) through reset SHALL produce one rise_o pulse SYNC_STAGES+DEBOUNCE_CYCLES cycles after rst_ni release.

Structure
REQ-028: Package fpga_pad_cond_pkg SHALL hold the FSM state enum rst_seq_state_e (HOLD, COUNT, RUN) and default parameter constants.
REQ-029: Per-channel synchroniser+debouncer+edge logic SHALL be sub-module pad_debounce, generated NUM_IN times; reset sequencer stays in the top.

Verification (NUM_IN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, INVERT_MASK=4'b1000)
REQ-030: Release rst_ni, pad_reset_i=0 -> soc_rst_no 0 for 11 cycles after release, then 1; in_o[3] rises with rise_o[3] pulse at cycle 6.
REQ-031: in_i[0] 0->1 held -> in_o[0]=1 and rise_o[0] one-cycle pulse exactly 6 cycles later; fall_o[0] stays 0.
REQ-032: in_i[1] 3-cycle high pulse -> in_o[1], rise_o[1] stay 0; second 5-cycle pulse -> rise_o[1] then fall_o[1].
REQ-033: pad_reset_i pulsed at COUNT cycle 5 -> FSM to HOLD, soc_rst_no stays 0, full 8-cycle hold restarts after release.
REQ-034: In RUN, pad_reset_i=1 -> soc_rst_no 0 after 3 cycles; rst_ni low mid-debounce -> all outputs 0 immediately.
